cic_comb_decim: RTL and testbench

Comb-and-decimate back half of the 3-stage CIC decimation filter. It takes the free-running 17-bit output of the integrator section on every `clk` cycle and keeps one sample in every R. It passes the kept samples through N = 3 comb (differentiator) stages and presents the result with a one-cycle valid strobe. It sits directly after the integrator section and feeds the downstream compensation or sample-sink logic at fs/R.

---
 rtl/cic_comb_decim_pkg.sv | 34 +++
 rtl/cic_comb_decim_if.sv | 19 +
 rtl/cic_comb_decim_stage.sv | 44 ++++
 rtl/cic_comb_decim.sv | 76 +++++++
 tb/tb_cic_comb_decim.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cic_comb_decim_pkg.sv
// Shared CIC constants and helpers. The integrator section and the
// comb/decimate section both import this so their widths stay in step.
package cic_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Integer power, used to derive the CIC bit growth.
    function automatic int ipow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) begin
            r = r * b;
        end
        return r;
    endfunction

    localparam int CIC_R    = 5;
    localparam int CIC_N    = 3;
    localparam int CIC_M    = 1;
    localparam int CIC_IN_W = 10;
    // Bit growth is ceil(N*log2(R*M)) = clog2((R*M)^N); 10 + 7 = 17 here.
    localparam int CIC_ACC_W = CIC_IN_W + clog2(ipow(CIC_R * CIC_M, CIC_N));

    typedef logic signed [CIC_ACC_W-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_decim_if.sv
// Sample bus between the integrator section (master) and the
// comb/decimate section (slave).
interface cic_comb_decim_if
    import cic_pkg::*;
#(
    parameter int IN_W  = CIC_ACC_W,
    parameter int OUT_W = CIC_ACC_W,
    parameter int PH_W  = clog2(CIC_R)
) ();

    logic signed [IN_W-1:0]  din;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_vld;
    logic [PH_W-1:0]         phase;

    modport master (output din, input dout, input dout_vld, input phase);
    modport slave  (input din, output dout, output dout_vld, output phase);

endinterface

// File: rtl/cic_comb_decim_stage.sv
// One CIC comb (differentiator) stage: out = in - in delayed by M
// decimated samples. The delay line only advances on the decimation
// strobe; the subtraction is combinational so the whole chain settles
// within the strobe cycle.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = CIC_ACC_W,
    parameter int M = CIC_M
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] in,
    output logic signed [W-1:0] out
);

    // Modulo-2^W difference; wrap is what lets integrator overflow cancel.
    function automatic logic signed [W-1:0] wrap_sub(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        return a - b;
    endfunction

    logic signed [W-1:0] dly_p0 [M];

    // Delay line: shift in the stage input on each decimation strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < M; i++) begin
                dly_p0[i] <= '0;
            end
        end else if (en) begin
            dly_p0[0] <= in;
            for (int i = 1; i < M; i++) begin
                dly_p0[i] <= dly_p0[i-1];
            end
        end
    end

    assign out = wrap_sub(in, dly_p0[M-1]);

endmodule

// File: rtl/cic_comb_decim.sv
// Comb-and-decimate half of the CIC decimator: keeps one integrator
// sample in R, runs it through N comb stages and registers the result
// with a one-cycle valid strobe.
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int IN_W  = CIC_ACC_W,
    parameter int OUT_W = CIC_ACC_W,
    parameter int R     = CIC_R,
    parameter int M     = CIC_M,
    parameter int N     = CIC_N
) (
    input  logic             clk,
    input  logic             rst,
    cic_comb_decim_if.slave  bus
);

    localparam int PH_W = clog2(R);

    logic [PH_W-1:0]        cnt_p0;
    logic                   dec_en_p0;
    logic signed [IN_W-1:0] stg [0:N];
    logic signed [OUT_W-1:0] dout_p1;
    logic                   vld_p1;

    // ---- p0: decimation phase and comb chain on the raw integrator sample
    assign dec_en_p0 = (cnt_p0 == PH_W'(R - 1));

    // Decimation counter 0..R-1, free running from reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p0 <= '0;
        end else if (dec_en_p0) begin
            cnt_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    assign stg[0] = bus.din;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_comb
            cic_comb_stage #(
                .W (IN_W),
                .M (M)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (dec_en_p0),
                .in  (stg[g]),
                .out (stg[g+1])
            );
        end
    endgenerate

    // ---- p1: registered output and strobe
    // Capture the comb result on each strobe; hold it in between.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= dec_en_p0;
            if (dec_en_p0) begin
                dout_p1 <= OUT_W'(stg[N]);
            end
        end
    end

    assign bus.dout     = dout_p1;
    assign bus.dout_vld = vld_p1;
    assign bus.phase    = cnt_p0;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Directed bench for cic_comb_decim: step response (M=1 and M=2),
// DC gain and wrap through a behavioural integrator, impulse response
// and asynchronous mid-operation reset.
module tb_cic_comb_decim;
    import cic_pkg::*;

    localparam int W  = 17;
    localparam int PW = clog2(5);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cic_comb_decim_if #(.IN_W(W), .OUT_W(W), .PH_W(PW)) bus  ();
    cic_comb_decim_if #(.IN_W(W), .OUT_W(W), .PH_W(PW)) bus2 ();

    assign bus2.din = bus.din;

    cic_comb_decim #(.IN_W(W), .OUT_W(W), .R(5), .M(1), .N(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cic_comb_decim #(.IN_W(W), .OUT_W(W), .R(5), .M(2), .N(3)) u_dut_m2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Upstream integrator model (three registered accumulators, wrapping).
    cic_acc_t         i1, i2, i3;
    logic signed [9:0] xin;
    logic             use_int;
    cic_acc_t         x_dir;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i3 = i3 + i2;
        i2 = i2 + i1;
        i1 = i1 + cic_acc_t'(xin);
        bus.din = use_int ? i3 : x_dir;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        i1 = '0;
        i2 = '0;
        i3 = '0;
        bus.din = use_int ? i3 : x_dir;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic next_strobe(output int v, output int gap);
        int k;
        k = 0;
        v = 0;
        do begin
            tick();
            k++;
        end while (!bus.dout_vld && k < 20);
        if (!bus.dout_vld) check("strobe_timeout", k, 0);
        else v = int'(bus.dout);
        gap = k;
    endtask

    task automatic run_step(input string pfx);
        int e1 [7] = '{1, -2, 1, 0, 0, 0, 0};
        int e2 [7] = '{1, 1, -2, -2, 1, 1, 0};
        int v, g;
        use_int = 1'b0;
        x_dir   = 17'sd1;
        xin     = '0;
        hold_reset();
        check({pfx, "_phase_at_release"}, int'(bus.phase), 0);
        for (int i = 0; i < 7; i++) begin
            next_strobe(v, g);
            check($sformatf("%s_m1_s%0d", pfx, i), v, e1[i]);
            check($sformatf("%s_m2_s%0d", pfx, i), int'(bus2.dout), e2[i]);
            check($sformatf("%s_m2_vld_s%0d", pfx, i), int'(bus2.dout_vld), 1);
            check($sformatf("%s_gap_s%0d", pfx, i), g, 5);
        end
        // Strobe lasts exactly one cycle.
        tick();
        check({pfx, "_vld_one_cycle"}, int'(bus.dout_vld), 0);
    endtask

    task automatic dc(input string tag, input int x, input int expv, input int nchk);
        int v, g;
        xin = 10'(x);
        for (int i = 0; i < 6; i++) next_strobe(v, g);
        for (int i = 0; i < nchk; i++) begin
            next_strobe(v, g);
            check($sformatf("%s_s%0d", tag, i), v, expv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int v, g, k, sum;
        use_int = 1'b0;
        x_dir   = '0;
        xin     = '0;
        i1 = '0; i2 = '0; i3 = '0;
        bus.din = '0;

        // Power-up reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", int'(bus.dout), 0);
        check("rst_vld", int'(bus.dout_vld), 0);
        check("rst_phase", int'(bus.phase), 0);
        check("rst_m2_dout", int'(bus2.dout), 0);

        run_step("step");

        // DC gain through the integrator, then sustained wrap
        use_int = 1'b1;
        xin     = '0;
        hold_reset();
        dc("dc_p1", 1, 125, 3);
        dc("dc_p511", 511, 63875, 3);
        dc("dc_m512", -512, -64000, 3);
        dc("wrap_511", 511, 63875, 66);

        // Asynchronous reset mid-operation with live delay lines
        k = 0;
        while (bus.phase != 3'd3 && k < 10) begin
            tick();
            k++;
        end
        check("midrst_phase_pre", int'(bus.phase), 3);
        check("midrst_dout_pre", int'(bus.dout), 63875);
        #2 rst = 1'b0;
        #1;
        check("midrst_dout", int'(bus.dout), 0);
        check("midrst_vld", int'(bus.dout_vld), 0);
        check("midrst_phase", int'(bus.phase), 0);
        check("midrst_m2_dout", int'(bus2.dout), 0);

        run_step("rerun");

        // Impulse through the integrator, aligned to phase 0
        use_int = 1'b1;
        xin     = '0;
        hold_reset();
        xin = 10'sd1;
        tick();
        xin = '0;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            next_strobe(v, g);
            sum += v;
            check($sformatf("imp_nonneg_s%0d", i), int'(v < 0), 0);
            if (i >= 5) check($sformatf("imp_zero_s%0d", i), v, 0);
        end
        check("imp_sum", sum, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
